// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the up/down modulo counter family.
//   count_dir_t       : count direction (DIR_UP=0, DIR_DOWN=1)
//   CNT_DEFAULT_WIDTH : default counter width
//   is_terminal()     : terminal-count test for a given count, direction and modulus
package counter_pkg;

  localparam int unsigned CNT_DEFAULT_WIDTH = 3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } count_dir_t;

  // True at the last value reachable in the current direction.
  function automatic logic is_terminal(input int unsigned q,
                                       input count_dir_t  dir,
                                       input int unsigned modulus);
    logic r_term;
    r_term = 1'b0;
    if (dir == DIR_UP) r_term = (q == modulus - 1);
    else               r_term = (q == 0);
    return r_term;
  endfunction

endpackage

// File: rtl/updown_next.sv
// updown_next: combinational next-count generator for updown_mod_counter.
//   i_q         : current count
//   i_dir       : count direction
//   i_en        : count enable; when low the count is passed through unchanged
//   o_next      : next count
//   o_wrap_step : the step runs past the end of the range
// Configuration: UPDOWN_SATURATE_EN defined -> saturate at the range ends
// instead of wrapping.
module updown_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_DEFAULT_WIDTH,
  parameter int unsigned MODULUS = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  count_dir_t       i_dir,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap_step
);

  // One extra bit so MODULUS = 2**WIDTH wraps without truncation.
  localparam logic [WIDTH:0]   LAST   = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LAST_W = LAST[WIDTH-1:0];

  logic [WIDTH:0] w_q_ext;
  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;

  assign w_q_ext = {1'b0, i_q};
  assign w_inc   = w_q_ext + (WIDTH+1)'(1);
  assign w_dec   = w_q_ext - (WIDTH+1)'(1);

  always_comb begin
    o_next      = i_q;
    o_wrap_step = 1'b0;
    if (i_en) begin
      if (i_dir == DIR_UP) begin
        if (w_inc > LAST) begin
          o_wrap_step = 1'b1;
`ifdef UPDOWN_SATURATE_EN
          o_next      = LAST_W;
`else
          o_next      = '0;
`endif
        end else begin
          o_next = w_inc[WIDTH-1:0];
        end
      end else begin
        // Borrow into the extra bit means the count was 0.
        if (w_dec[WIDTH]) begin
          o_wrap_step = 1'b1;
`ifdef UPDOWN_SATURATE_EN
          o_next      = '0;
`else
          o_next      = LAST_W;
`endif
        end else begin
          o_next = w_dec[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down counter with programmable modulus, parallel load,
// count enable, terminal count, wrap pulse and sticky overflow.
//   clk     : clock (rising edge)
//   reset   : asynchronous active-high reset
//   en      : count enable
//   m       : direction, 0 = up, 1 = down
//   load    : synchronous load of din (clamped to MODULUS-1)
//   din     : load value
//   clr_ovf : clear sticky overflow (a same-edge set wins)
//   q       : current count
//   tc      : terminal count, combinational from q and m
//   wrap    : one-cycle pulse after a wrap step
//   ovf     : sticky overflow
// Configuration: UPDOWN_SATURATE_EN defined -> saturate instead of wrap.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_DEFAULT_WIDTH,
  parameter int unsigned MODULUS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             m,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be in 1..31");
  end
  if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST_W  = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ovf;

  count_dir_t       w_dir;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_step;
  logic             w_clamp;
  logic             w_wrap_set;
  logic             w_ovf_set;

  assign w_dir = count_dir_t'(m);

  updown_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .i_q         (r_q),
    .i_dir       (w_dir),
    .i_en        (en),
    .o_next      (w_next),
    .o_wrap_step (w_wrap_step)
  );

  // Load outranks counting, so a wrap step during load is discarded.
  assign w_clamp    = load && ({1'b0, din} >= MOD_EXT);
  assign w_wrap_set = !load && w_wrap_step;
  assign w_ovf_set  = w_clamp || w_wrap_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_wrap <= w_wrap_set;
      r_ovf  <= w_ovf_set || (r_ovf && !clr_ovf);
      if (load) r_q <= w_clamp ? LAST_W : din;
      else      r_q <= w_next;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign ovf  = r_ovf;
  assign tc   = is_terminal(32'(r_q), w_dir, MODULUS);

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable, terminal-count and wrap indications, and a sticky overflow flag. It generalises the team's fixed 3-bit T-flip-flop up/down counter to arbitrary width and modulus. It serves as the standard counting primitive for timers, address sequencers and event tallies in the design.

## Interface
- `WIDTH`, default 3: counter width in bits, at least 1.
- `MODULUS`, default 8: count range is 0 to MODULUS-1. Legal range is 2 to 2^WIDTH; an illegal value triggers an elaboration-time `$error`.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `en`  input  1: count enable (the T input); steps the counter when high.
- `m`  input  1: mode select; 0 counts up, 1 counts down.
- `load`  input  1: synchronous parallel load.
- `din`  input  WIDTH: load value.
- `clr_ovf`  input  1: clears the sticky overflow flag.
- `q`  output  WIDTH: current count.
- `tc`  output  1: terminal count, combinational from `q` and `m`.
- `wrap`  output  1: registered one-cycle pulse.
- `ovf`  output  1: sticky overflow flag.

## Operation
- **Reset** (asynchronous, active-high): `q`=0, `wrap`=0, `ovf`=0. `tc` follows from `q` and `m`, so it is 1 while `m`=1 and 0 while `m`=0.
- **Per-edge priority:** `load` > `en` > hold.
- **Load:** `q` <= `din` when `din` < MODULUS. Otherwise `q` <= MODULUS-1 and `ovf` is set. A load never asserts `wrap`.
- **Count up** (`en`=1, `m`=0): `q`+1. At MODULUS-1 the counter wraps to 0.
- **Count down** (`en`=1, `m`=1): `q`-1. At 0 the counter wraps to MODULUS-1.
- **Width rule:** the next value is computed at WIDTH+1 bits before comparison with MODULUS-1, so MODULUS=2^WIDTH wraps cleanly with no truncation error.
- **Terminal count:** `tc` = (`m`=0 and `q`=MODULUS-1) or (`m`=1 and `q`=0). It is independent of `en`.
- **Wrap pulse:** `wrap` goes high for exactly one cycle, on the edge after a wrap step occurs.
- **Overflow flag:** `ovf` is set on every wrap step or clamped load, and cleared by `clr_ovf`. If set and clear happen on the same edge, set wins.
- **Direction change:** a change of `m` takes effect on the next enabled edge. There is no dead cycle. `tc` re-evaluates immediately.
- **Hold:** with `en`=0 and `load`=0, `q`, `wrap` (forced to 0) and `ovf` hold.
- **Reset mid-count:** asynchronous clear of all state. The first enabled edge after deassertion counts from 0.

## Timing
- `q` latency is one cycle from `en`/`load` sampling.
- `tc` has zero-cycle latency (combinational from registered `q` and input `m`).
- `wrap` lags the wrapping edge by one cycle. During that cycle `q` already shows the wrapped value.
- `reset` assertion clears all state without a clock edge. Deassertion must be synchronised externally to `clk`.
- There is no back-to-back restriction: `en` held high counts every cycle.

## Configuration
- **`UPDOWN_SATURATE_EN` defined:** the counter saturates instead of wrapping.
  - Up: holds at MODULUS-1.
  - Down: holds at 0.
  - `wrap` pulses on each enabled edge attempted past the end, and `ovf` sets the same way.
  - `tc` is unchanged.
- **`UPDOWN_SATURATE_EN` undefined:** modulo wrap behaviour exactly as described under Operation.

## Structure
- **Package `counter_pkg`:**
  - Typedef `count_dir_t` (DIR_UP=0, DIR_DOWN=1).
  - Helper function `is_terminal(q, dir, modulus)`.
  - Constant `CNT_DEFAULT_WIDTH`=3.
- **Sub-module `updown_next`:** purely combinational. Takes `q`, `m` and `en`; produces the next count and a `wrap_step` flag. It contains the WIDTH+1 arithmetic and the saturate/wrap selection, and is instantiated once.

## Test plan
- **Reset then count up:** WIDTH=3, MODULUS=8, `m`=0, `en`=1, release `reset` → `q` steps 0,1,…,7,0. `tc`=1 at `q`=7. `wrap`=1 only in the cycle `q`=0 after 7. `ovf`=1 afterwards.
- **Non-power-of-two modulus, down:** MODULUS=6, `m`=1, `en`=1 → `q` steps 0,5,4,3,2,1,0,5. `tc`=1 at `q`=0. `wrap` pulses after 0→5.
- **Load, in range and clamped:** `load`=1 with `din`=3 → `q`=3, `ovf` unchanged. Then `din`=7 with MODULUS=6 → `q`=5, `ovf`=1, `wrap`=0.
- **Simultaneous events:** `load`=1 and `en`=1 → load wins. Then `clr_ovf`=1 on a wrapping edge → `ovf` stays 1. Then `clr_ovf` alone → `ovf`=0.
- **Mid-stream direction change and reset:** count up to 5, set `m`=1 → next values 4,3. Pulse `reset` between clock edges → `q`=0 immediately; `ovf` and `wrap` are 0.
- **With `UPDOWN_SATURATE_EN`:** MODULUS=8, count up from 6 → `q`=7,7,7. `wrap` pulses on each edge at 7. `ovf`=1.
